// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_M_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = $clog2(DIV_M_DEFAULT);

    // Counter width for an M-cycle iteration; never narrower than one bit.
    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sub_trial_nbit.sv
// Combinational (N+1)-bit trial subtractor: minuend minus zero-extended divisor, with sign.
module sub_trial_nbit #(
    parameter int N = 4
) (
    input  logic [N:0]   minuend,
    input  logic [N-1:0] subtrahend,
    output logic [N:0]   diff,
    output logic         non_neg
);

    // One guard bit above the N+1 operand bits carries the borrow.
    logic [N+1:0] wide;

    assign wide    = {1'b0, minuend} - {2'b00, subtrahend};
    assign diff    = wide[N:0];
    assign non_neg = ~wide[N+1];

endmodule

// File: rtl/div_mnbit_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done framing.
// Optional macro DIV_ZERO_DETECT_EN short-circuits b=0 straight to DONE with div_zero set.
module div_mnbit_seq
    import div_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] quot,
    output logic [N-1:0] rem,
    output logic         div_zero
);

    if (M < N) begin : g_bad_mn
        $error("div_mnbit_seq: M must be >= N");
    end
    if (N < 2) begin : g_bad_n
        $error("div_mnbit_seq: N must be >= 2");
    end

    localparam int CW = cnt_width(M);

    div_state_e   state_q, state_d;
    logic [M-1:0] dvd_q, dvd_d;
    logic [M-1:0] quot_q, quot_d;
    logic [N-1:0] dvs_q, dvs_d;
    logic [N-1:0] rem_q, rem_d;
    logic [N:0]   pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         dz_q, dz_d;

    logic [N:0]   trial_in;
    logic [N:0]   trial_diff;
    logic         trial_ok;

    // Dividend bits leave from the MSB while quotient bits enter at the LSB.
    assign trial_in = {pr_q[N-1:0], dvd_q[M-1]};

    sub_trial_nbit #(.N(N)) u_trial (
        .minuend    (trial_in),
        .subtrahend (dvs_q),
        .diff       (trial_diff),
        .non_neg    (trial_ok)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = a;
                    dvs_d   = b;
                    pr_d    = '0;
                    cnt_d   = CW'(M - 1);
                    dz_d    = 1'b0;
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    if (b == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                pr_d  = trial_ok ? trial_diff : trial_in;
                dvd_d = {dvd_q[M-2:0], trial_ok};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = dvd_d;
                    rem_d   = pr_d[N-1:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = dz_q;

endmodule
